// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the LSU memory responder.
package cpu_types_pkg;

  // One 32-bit memory word.
  typedef logic [31:0] word_t;

  // Responder sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Byte-address bits below the word index (32-bit words).
  localparam int unsigned ADDR_LSB = 2;

  // Number of word-index bits for a backing store of the given depth.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/lsu_mem_array.sv
// Backing store: synchronous write, combinational read, DEPTH x 32 bits.
// Contents are deliberately not reset.
module lsu_mem_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             CLK,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  word_t            wdata_i,
  output word_t            rdata_o
);

  word_t mem_q [DEPTH];

  // Commit a write at the end of the cycle in which it is enabled.
  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/lsu_mem_responder.sv
// Fixed-latency memory responder serving one instruction and one data
// request port from a shared word store, with a halt/flush sequence.
module lsu_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output word_t imemload,
  output logic  icacheHit,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output word_t dmemload,
  output logic  dcacheHit,
  input  logic  chalt,
  output logic  flushed
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  word_t            wdata_q, wdata_d;
  logic             halt_q, halt_d;
  logic             dhit_q, dhit_d;
  logic             ihit_q, ihit_d;
  word_t            dload_q, dload_d;
  word_t            iload_q, iload_d;
  logic             flushed_q, flushed_d;

  logic             req_s;
  logic             mem_we_s;
  word_t            rdata_s;
  logic [IDX_W-1:0] didx_s, iidx_s;
  logic             unused_addr_bits_s;

  // Word index extraction: byte offset and bits above the store are dropped,
  // so addresses wrap modulo DEPTH*4.
  assign didx_s = dmemaddr[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign iidx_s = imemaddr[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign unused_addr_bits_s = ^{dmemaddr[31:IDX_W+ADDR_LSB], dmemaddr[ADDR_LSB-1:0],
                                imemaddr[31:IDX_W+ADDR_LSB], imemaddr[ADDR_LSB-1:0]};

  lsu_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .CLK     (CLK),
    .we_i    (mem_we_s),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_s)
  );

  // Is the request that owns the current access still being held?
  always_comb begin
    req_s = 1'b0;
    case (state_q)
      DACC:    req_s = wr_q ? dmemWEN : dmemREN;
      IACC:    req_s = imemREN;
      default: req_s = 1'b0;
    endcase
  end

  // Next-state, counters, latched request and registered output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    halt_d    = halt_q;
    dhit_d    = 1'b0;
    ihit_d    = 1'b0;
    dload_d   = dload_q;
    iload_d   = iload_q;
    flushed_d = flushed_q;
    mem_we_s  = 1'b0;

    case (state_q)
      IDLE: begin
        halt_d = 1'b0;
        if (chalt) begin
          state_d = FLUSH;
          fcnt_d  = 8'(FLUSH_CYCLES);
        end else if (dmemREN || dmemWEN) begin
          state_d = DACC;
          idx_d   = didx_s;
          wr_d    = dmemWEN;
          wdata_d = dmemstore;
          cnt_d   = 4'(LATENCY);
        end else if (imemREN) begin
          state_d = IACC;
          idx_d   = iidx_s;
          wr_d    = 1'b0;
          cnt_d   = 4'(LATENCY);
        end else begin
          state_d = IDLE;
        end
      end

      DACC, IACC: begin
        halt_d = halt_q | chalt;
        if (cnt_q == 4'd0) begin
          // Hit cycle: a write commits now; then flush, chain a waiting
          // instruction fetch, or go idle.
          mem_we_s = (state_q == DACC) && wr_q && nRST;
          halt_d   = 1'b0;
          cnt_d    = 4'd0;
          if (halt_q || chalt) begin
            state_d = FLUSH;
            fcnt_d  = 8'(FLUSH_CYCLES);
          end else if ((state_q == DACC) && imemREN) begin
            state_d = IACC;
            idx_d   = iidx_s;
            wr_d    = 1'b0;
            cnt_d   = 4'(LATENCY);
          end else begin
            state_d = IDLE;
          end
        end else if (!req_s) begin
          // Request withdrawn before its hit: drop it silently.
          halt_d = 1'b0;
          cnt_d  = 4'd0;
          if (halt_q || chalt) begin
            state_d = FLUSH;
            fcnt_d  = 8'(FLUSH_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (state_q == DACC) begin
              dhit_d = 1'b1;
              if (!wr_q) begin
                dload_d = rdata_s;
              end else begin
                dload_d = dload_q;
              end
            end else begin
              ihit_d  = 1'b1;
              iload_d = rdata_s;
            end
          end else begin
            dhit_d = 1'b0;
          end
        end
      end

      FLUSH: begin
        if (fcnt_q <= 8'd1) begin
          state_d   = DONE;
          fcnt_d    = 8'd0;
          flushed_d = 1'b1;
        end else begin
          fcnt_d = fcnt_q - 8'd1;
        end
      end

      DONE: begin
        state_d   = DONE;
        flushed_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      fcnt_q    <= 8'd0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      halt_q    <= 1'b0;
      dhit_q    <= 1'b0;
      ihit_q    <= 1'b0;
      dload_q   <= 32'd0;
      iload_q   <= 32'd0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      halt_q    <= halt_d;
      dhit_q    <= dhit_d;
      ihit_q    <= ihit_d;
      dload_q   <= dload_d;
      iload_q   <= iload_d;
      flushed_q <= flushed_d;
    end
  end

  assign dcacheHit = dhit_q;
  assign icacheHit = ihit_q;
  assign dmemload  = dload_q;
  assign imemload  = iload_q;
  assign flushed   = flushed_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed self-checking bench for lsu_mem_responder (default parameters).
module tb_lsu_mem_responder;
  import cpu_types_pkg::*;

  localparam int LAT = 2;
  localparam int FLC = 16;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN, dmemREN, dmemWEN, chalt;
  word_t imemaddr, dmemaddr, dmemstore;
  word_t imemload, dmemload;
  logic  icacheHit, dcacheHit, flushed;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    logic  ren;
    logic  wen;
    word_t addr;
    word_t data;
    word_t exp_load;
  } dvec_t;

  dvec_t vecs [8];

  lsu_mem_responder #(
    .LATENCY      (LAT),
    .DEPTH        (1024),
    .FLUSH_CYCLES (FLC)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .imemload  (imemload),
    .icacheHit (icacheHit),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dmemload  (dmemload),
    .dcacheHit (dcacheHit),
    .chalt     (chalt),
    .flushed   (flushed)
  );

  // Free-running clock, 10 time-unit period.
  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Cycles (after the current one) until dcacheHit, or -1 if none within budget.
  task automatic wait_d_hit(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (dcacheHit === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  // One complete data access: hit must arrive LAT+1 cycles after the request
  // cycle, last exactly one cycle, and leave dmemload at the expected value.
  task automatic run_dacc(input string name, input logic ren, input logic wen,
                          input word_t addr, input word_t data, input word_t exp_load);
    int cyc;
    dmemREN   = ren;
    dmemWEN   = wen;
    dmemaddr  = addr;
    dmemstore = data;
    wait_d_hit(cyc);
    check32($sformatf("%s_latency", name), 32'(cyc), 32'(LAT + 1));
    check32($sformatf("%s_load", name), dmemload, exp_load);
    check32($sformatf("%s_no_ihit", name), {31'd0, icacheHit}, 32'd0);
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    tick();
    check32($sformatf("%s_pulse1", name), {31'd0, dcacheHit}, 32'd0);
  endtask

  initial begin
    int  cyc;
    int  icyc;
    logic seen;

    vecs[0] = '{"wr40",    1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{"rd40",    1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{"wr1000",  1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 32'hDEAD_BEEF};
    vecs[3] = '{"rd0wrap", 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{"rw80",    1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0000_0001};
    vecs[5] = '{"rd80",    1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 32'h1234_5678};
    vecs[6] = '{"rd43",    1'b1, 1'b0, 32'h0000_0043, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[7] = '{"rd1040",  1'b1, 1'b0, 32'h0000_1040, 32'h0000_0000, 32'hDEAD_BEEF};

    nRST = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; chalt = 1'b0;
    imemaddr = 32'd0; dmemaddr = 32'd0; dmemstore = 32'd0;

    // Reset state.
    tick();
    tick();
    check32("rst_dhit", {31'd0, dcacheHit}, 32'd0);
    check32("rst_ihit", {31'd0, icacheHit}, 32'd0);
    check32("rst_flushed", {31'd0, flushed}, 32'd0);
    check32("rst_dload", dmemload, 32'd0);
    check32("rst_iload", imemload, 32'd0);
    nRST = 1'b1;
    tick();

    // Table of single data accesses.
    for (int i = 0; i < 8; i++) begin
      run_dacc(vecs[i].name, vecs[i].ren, vecs[i].wen, vecs[i].addr,
               vecs[i].data, vecs[i].exp_load);
    end

    // Simultaneous instruction and data reads: data first, fetch LAT+1 later.
    imemREN  = 1'b1; imemaddr = 32'h0000_0040;
    dmemREN  = 1'b1; dmemaddr = 32'h0000_0080;
    wait_d_hit(cyc);
    check32("both_dlat", 32'(cyc), 32'(LAT + 1));
    check32("both_dload", dmemload, 32'h1234_5678);
    check32("both_ihit_at_dhit", {31'd0, icacheHit}, 32'd0);
    dmemREN = 1'b0;
    icyc = -1;
    seen = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (dcacheHit === 1'b1) seen = 1'b1;
      if (icacheHit === 1'b1) begin
        icyc = n;
        break;
      end
    end
    check32("both_ilat", 32'(icyc), 32'(LAT + 1));
    check32("both_dhit_at_ihit", {31'd0, seen}, 32'd0);
    check32("both_iload", imemload, 32'hDEAD_BEEF);
    imemREN = 1'b0;
    tick();
    check32("both_ipulse1", {31'd0, icacheHit}, 32'd0);

    // Write withdrawn after one cycle: no hit, memory untouched.
    dmemWEN = 1'b1; dmemaddr = 32'h0000_0040; dmemstore = 32'hCAFE_F00D;
    tick();
    dmemWEN = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (dcacheHit === 1'b1) seen = 1'b1;
    end
    check32("abort_nohit", {31'd0, seen}, 32'd0);
    run_dacc("abort_rd40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);

    // Reset in the middle of a write: outputs clear, old data survives.
    dmemWEN = 1'b1; dmemaddr = 32'h0000_0080; dmemstore = 32'h55AA_55AA;
    tick();
    tick();
    nRST = 1'b0;
    tick();
    check32("mrst_dhit", {31'd0, dcacheHit}, 32'd0);
    check32("mrst_ihit", {31'd0, icacheHit}, 32'd0);
    check32("mrst_flushed", {31'd0, flushed}, 32'd0);
    check32("mrst_dload", dmemload, 32'd0);
    check32("mrst_iload", imemload, 32'd0);
    dmemWEN = 1'b0;
    tick();
    check32("mrst_dhit2", {31'd0, dcacheHit}, 32'd0);
    nRST = 1'b1;
    tick();
    run_dacc("mrst_rd80", 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678);
    run_dacc("mrst_rd40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);

    // Halt mid-access: the access completes, then FLUSH lasts FLC cycles
    // (flushed rises FLC+1 cycles after the hit cycle), then DONE is terminal.
    dmemREN = 1'b1; dmemaddr = 32'h0000_0000;
    tick();
    chalt = 1'b1;
    wait_d_hit(cyc);
    check32("halt_dlat", 32'(cyc), 32'(LAT));
    check32("halt_dload", dmemload, 32'h0000_0001);
    dmemREN = 1'b0;
    icyc = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (flushed === 1'b1) begin
        icyc = n;
        break;
      end
    end
    check32("halt_flush_cycles", 32'(icyc), 32'(FLC + 1));
    dmemREN = 1'b1; imemREN = 1'b1; dmemaddr = 32'h0000_0040; imemaddr = 32'h0000_0040;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if ((dcacheHit === 1'b1) || (icacheHit === 1'b1)) seen = 1'b1;
    end
    check32("done_nohit", {31'd0, seen}, 32'd0);
    check32("done_flushed", {31'd0, flushed}, 32'd1);
    check32("done_dload_held", dmemload, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
